hamming_serial_encoder: RTL and testbench

HAMMING_SERIAL_ENCODER -- requirements
Module: hamming_serial_encoder

---
 rtl/hamming_serial_encoder_if.sv | 32 +++
 rtl/hamming_serial_encoder.sv | 139 +++++++++++++
 tb/tb_hamming_serial_encoder.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hamming_serial_encoder_if.sv
// Handshake and serial-output bundle for the Hamming (8,4) serial encoder.
// The producer side (master) drives nibbles; the encoder side (slave) returns
// the ready flag and the serial frame signals.
interface hamming_serial_encoder_if;
  logic [3:0] data_in;
  logic       data_valid;
  logic       data_ready;
  logic       out;
  logic       en;
  logic       frame_start;
  logic       busy;

  modport master (
    output data_in,
    output data_valid,
    input  data_ready,
    input  out,
    input  en,
    input  frame_start,
    input  busy
  );

  modport slave (
    input  data_in,
    input  data_valid,
    output data_ready,
    output out,
    output en,
    output frame_start,
    output busy
  );
endinterface

// File: rtl/hamming_serial_encoder.sv
// Serial extended-Hamming (8,4) encoder.
// Accepted nibbles are encoded into an 8-bit codeword held in a one-entry
// holding register, then shifted out LSB first with en high for the 8 bit
// cycles. An optional run of GAP idle cycles separates consecutive frames.
module hamming_serial_encoder #(
  parameter int GAP = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  hamming_serial_encoder_if.slave   bus
);

  localparam bit         HAS_GAP  = (GAP != 0);
  localparam logic [3:0] GAP_LOAD = HAS_GAP ? 4'(GAP - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t     state;
  state_t     state_n;
  logic [7:0] hold_word;
  logic [7:0] shift_word;
  logic       hold_full;
  logic [2:0] bit_cnt;
  logic [3:0] gap_cnt;
  logic       accept;
  logic       load_shift;
  logic       last_bit;
  logic       sending;

  // Codeword layout: word[j] = cj, data in c1..c4, checks in c5..c7,
  // overall even parity in c0.
  function automatic logic [7:0] encode(input logic [3:0] d);
    logic [7:0] w;
    w[1] = d[3];
    w[2] = d[2];
    w[3] = d[1];
    w[4] = d[0];
    w[5] = w[1] ^ w[3] ^ w[4];
    w[6] = w[1] ^ w[2] ^ w[3];
    w[7] = w[2] ^ w[3] ^ w[4];
    w[0] = ^w[7:1];
    return w;
  endfunction

  // Ready is purely the registered hold state, so it never depends on data_valid.
  assign accept   = bus.data_valid && !hold_full;
  assign last_bit = (bit_cnt == 3'd7);
  assign sending  = (state == ST_SEND);

  assign bus.data_ready  = !hold_full;
  assign bus.en          = sending;
  assign bus.out         = sending && shift_word[0];
  assign bus.frame_start = sending && (bit_cnt == 3'd0);
  assign bus.busy        = (state != ST_IDLE) || hold_full;

  // State register; reset aborts any frame or gap in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state logic and the hold-to-shift transfer strobe.
  always_comb begin
    state_n    = state;
    load_shift = 1'b0;
    case (state)
      ST_IDLE: begin
        if (hold_full) begin
          load_shift = 1'b1;
          state_n    = ST_SEND;
        end
      end
      ST_SEND: begin
        if (last_bit) begin
          if (HAS_GAP) begin
            state_n = ST_GAP;
          end else if (hold_full) begin
            load_shift = 1'b1;
          end else begin
            state_n = ST_IDLE;
          end
        end
      end
      ST_GAP: begin
        // A queued frame follows the last gap cycle directly, so exactly GAP
        // idle cycles separate back-to-back frames.
        if (gap_cnt == 4'd0) begin
          if (hold_full) begin
            load_shift = 1'b1;
            state_n    = ST_SEND;
          end else begin
            state_n = ST_IDLE;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Holding register, output shifter, bit counter and gap counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_full  <= 1'b0;
      hold_word  <= '0;
      shift_word <= '0;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
    end else begin
      if (accept) begin
        hold_word <= encode(bus.data_in);
        hold_full <= 1'b1;
      end else if (load_shift) begin
        hold_full <= 1'b0;
      end

      if (load_shift) begin
        shift_word <= hold_word;
        bit_cnt    <= '0;
      end else if (sending) begin
        shift_word <= {1'b0, shift_word[7:1]};
        bit_cnt    <= bit_cnt + 3'd1;
      end

      if (sending && last_bit) begin
        gap_cnt <= GAP_LOAD;
      end else if ((state == ST_GAP) && (gap_cnt != 4'd0)) begin
        gap_cnt <= gap_cnt - 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_hamming_serial_encoder.sv
// Testbench for hamming_serial_encoder: a GAP=0 and a GAP=3 instance share the
// clock and reset; sel routes the producer and the sampled outputs to one of them.
module tb_hamming_serial_encoder;

  logic       clk = 1'b0;
  logic       reset;
  logic       sel;
  logic       tb_valid;
  logic [3:0] tb_data;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  hamming_serial_encoder_if ifa ();
  hamming_serial_encoder_if ifb ();

  assign ifa.data_in    = tb_data;
  assign ifb.data_in    = tb_data;
  assign ifa.data_valid = tb_valid & ~sel;
  assign ifb.data_valid = tb_valid & sel;

  hamming_serial_encoder #(.GAP(0)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (ifa.slave)
  );

  hamming_serial_encoder #(.GAP(3)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (ifb.slave)
  );

  logic s_ready, s_out, s_en, s_fs, s_busy;
  assign s_ready = sel ? ifb.data_ready  : ifa.data_ready;
  assign s_out   = sel ? ifb.out         : ifa.out;
  assign s_en    = sel ? ifb.en          : ifa.en;
  assign s_fs    = sel ? ifb.frame_start : ifa.frame_start;
  assign s_busy  = sel ? ifb.busy        : ifa.busy;

  typedef struct {
    logic [3:0] nib;
    logic [7:0] word;
  } vec_t;

  vec_t       tbl [16];
  logic [3:0] stim [4];
  logic [7:0] expw [4];
  logic       en_log [64];
  logic       out_log [64];
  logic       fs_log [64];
  logic       rdy_log [64];
  logic       busy_log [64];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] syndrome(input logic [7:0] w);
    logic [7:0] r0, r1, r2;
    r0 = 8'b00111010;
    r1 = 8'b01001110;
    r2 = 8'b10011100;
    return {^(r2 & w), ^(r1 & w), ^(r0 & w)};
  endfunction

  // One nibble from idle: handshake, latency, 8-bit frame, decode checks.
  task automatic run_single(input int id, input logic [3:0] d, input logic [7:0] exp);
    logic [7:0] w;
    int         en_miss;
    int         fs_cnt;
    w       = '0;
    en_miss = 0;
    fs_cnt  = 0;
    tb_data  = d;
    tb_valid = 1'b1;
    check($sformatf("v%0d_ready_pre", id), 32'(s_ready), 1);
    @(posedge clk); #1;
    tb_valid = 1'b0;
    tb_data  = 4'($urandom);
    check($sformatf("v%0d_ready_held", id), 32'(s_ready), 0);
    check($sformatf("v%0d_busy_held", id), 32'(s_busy), 1);
    check($sformatf("v%0d_en_early", id), 32'(s_en), 0);
    @(posedge clk); #1;
    for (int k = 0; k < 8; k++) begin
      if (!s_en) en_miss++;
      if (s_fs) fs_cnt += (k == 0) ? 1 : 100;
      w[k]    = s_out;
      tb_data = 4'($urandom);
      @(posedge clk); #1;
    end
    check($sformatf("v%0d_en_missing", id), 32'(en_miss), 0);
    check($sformatf("v%0d_frame_start", id), 32'(fs_cnt), 1);
    check($sformatf("v%0d_en_after", id), 32'(s_en), 0);
    check($sformatf("v%0d_out_after", id), 32'(s_out), 0);
    check($sformatf("v%0d_busy_after", id), 32'(s_busy), 0);
    check($sformatf("v%0d_word", id), 32'(w), 32'(exp));
    check($sformatf("v%0d_syndrome", id), 32'(syndrome(w)), 0);
    check($sformatf("v%0d_decoded", id), 32'({w[1], w[2], w[3], w[4]}), 32'(d));
  endtask

  // Producer streaming stim[0..n-1] into the selected DUT while logging outputs.
  task automatic run_stream(input int n, input int cycles, input bit scramble);
    int idx;
    bit rdy_prev;
    idx      = 0;
    rdy_prev = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk); #1;
      if (tb_valid && rdy_prev) idx++;
      en_log[c]   = s_en;
      out_log[c]  = s_out;
      fs_log[c]   = s_fs;
      rdy_log[c]  = s_ready;
      busy_log[c] = s_busy;
      if (idx < n) begin
        tb_valid = 1'b1;
        tb_data  = (s_ready || !scramble) ? stim[idx] : 4'($urandom);
      end else begin
        tb_valid = 1'b0;
      end
      rdy_prev = s_ready;
    end
    check("stream_all_accepted", 32'(idx), 32'(n));
  endtask

  // Checks n logged frames against expw, separated by gap idle cycles.
  task automatic check_frames(input int n, input int gap, input string tag, output int f);
    logic [7:0] w;
    int         base;
    int         en_miss;
    int         fs_bad;
    int         gap_bad;
    f = -1;
    for (int i = 0; i < 64; i++) begin
      if (f < 0 && en_log[i]) f = i;
    end
    check({tag, "_frame_found"}, 32'(f >= 0 && f < 20), 1);
    if (f < 0 || f >= 20) return;
    for (int k = 0; k < n; k++) begin
      base    = f + k * (8 + gap);
      w       = '0;
      en_miss = 0;
      fs_bad  = 0;
      gap_bad = 0;
      for (int j = 0; j < 8; j++) begin
        if (!en_log[base + j]) en_miss++;
        if (fs_log[base + j] != (j == 0)) fs_bad++;
        w[j] = out_log[base + j];
      end
      if (k < n - 1) begin
        for (int g = 0; g < gap; g++) begin
          if (en_log[base + 8 + g] || out_log[base + 8 + g]) gap_bad++;
        end
      end
      check($sformatf("%s_f%0d_en", tag, k), 32'(en_miss), 0);
      check($sformatf("%s_f%0d_fs", tag, k), 32'(fs_bad), 0);
      check($sformatf("%s_f%0d_word", tag, k), 32'(w), 32'(expw[k]));
      if (k < n - 1 && gap > 0) check($sformatf("%s_f%0d_gap", tag, k), 32'(gap_bad), 0);
    end
    check({tag, "_en_end"}, 32'(en_log[f + n * 8 + (n - 1) * gap]), 0);
    check({tag, "_out_end"}, 32'(out_log[f + n * 8 + (n - 1) * gap]), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time bound");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int f;
    int en_cnt;
    reset    = 1'b1;
    sel      = 1'b0;
    tb_valid = 1'b0;
    tb_data  = 4'h0;
    tbl[0]  = '{4'h0, 8'h00};  tbl[1]  = '{4'h1, 8'hB1};
    tbl[2]  = '{4'h2, 8'hE8};  tbl[3]  = '{4'h3, 8'h59};
    tbl[4]  = '{4'h4, 8'hC5};  tbl[5]  = '{4'h5, 8'h74};
    tbl[6]  = '{4'h6, 8'h2D};  tbl[7]  = '{4'h7, 8'h9C};
    tbl[8]  = '{4'h8, 8'h63};  tbl[9]  = '{4'h9, 8'hD2};
    tbl[10] = '{4'hA, 8'h8B};  tbl[11] = '{4'hB, 8'h3A};
    tbl[12] = '{4'hC, 8'hA6};  tbl[13] = '{4'hD, 8'h17};
    tbl[14] = '{4'hE, 8'h4E};  tbl[15] = '{4'hF, 8'hFF};

    // Reset state of both instances.
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      check($sformatf("rst%0d_ready", s), 32'(s_ready), 1);
      check($sformatf("rst%0d_en", s), 32'(s_en), 0);
      check($sformatf("rst%0d_out", s), 32'(s_out), 0);
      check($sformatf("rst%0d_fs", s), 32'(s_fs), 0);
      check($sformatf("rst%0d_busy", s), 32'(s_busy), 0);
    end
    sel = 1'b0;
    #1;
    reset = 1'b0;

    // All 16 nibbles from idle; the first accept lands on the first edge after reset.
    for (int i = 0; i < 16; i++) begin
      run_single(i, tbl[i].nib, tbl[i].word);
    end

    // Back-to-back frames with GAP=0.
    stim[0] = 4'b0000; stim[1] = 4'b1111; stim[2] = 4'b0001;
    expw[0] = 8'h00;   expw[1] = 8'hFF;   expw[2] = 8'hB1;
    run_stream(3, 40, 1'b0);
    check_frames(3, 0, "b2b", f);
    en_cnt = 0;
    for (int i = 0; i < 40; i++) en_cnt += int'(en_log[i]);
    check("b2b_en_total", 32'(en_cnt), 24);
    if (f >= 0 && f < 20) begin
      check("b2b_ready_bit7", 32'(rdy_log[f + 7]), 0);
      check("b2b_ready_bit0", 32'(rdy_log[f + 8]), 1);
      check("b2b_ready_f1_bit7", 32'(rdy_log[f + 15]), 0);
      check("b2b_ready_f2_bit0", 32'(rdy_log[f + 16]), 1);
    end

    // Pending nibble held with valid=1 and junk data_in while not ready.
    stim[0] = 4'b0101; stim[1] = 4'b1100; stim[2] = 4'b0111;
    expw[0] = 8'h74;   expw[1] = 8'hA6;   expw[2] = 8'h9C;
    run_stream(3, 40, 1'b1);
    check_frames(3, 0, "hold", f);

    // GAP=3 instance with two queued nibbles.
    sel = 1'b1;
    #1;
    stim[0] = 4'b0110; stim[1] = 4'b1001;
    expw[0] = 8'h2D;   expw[1] = 8'hD2;
    run_stream(2, 40, 1'b0);
    check_frames(2, 3, "gap", f);
    if (f >= 0 && f < 20) begin
      check("gap_busy_in_gap", 32'(busy_log[f + 9]), 1);
      check("gap_en_first_gap", 32'(en_log[f + 8]), 0);
      check("gap_en_after_gap", 32'(en_log[f + 11]), 1);
    end
    check("gap_busy_end", 32'(busy_log[39]), 0);

    // Asynchronous reset at bit 4 with a second nibble queued.
    sel = 1'b0;
    #1;
    @(posedge clk); #1;
    tb_data  = 4'b1010;
    tb_valid = 1'b1;
    @(posedge clk); #1;
    tb_data = 4'b0011;
    @(posedge clk); #1;
    check("arst_en_bit0", 32'(s_en), 1);
    @(posedge clk); #1;
    tb_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("arst_en_bit4", 32'(s_en), 1);
    check("arst_queued", 32'(s_ready), 0);
    #2;
    reset = 1'b1;
    #1;
    check("arst_out", 32'(s_out), 0);
    check("arst_en", 32'(s_en), 0);
    check("arst_busy", 32'(s_busy), 0);
    check("arst_fs", 32'(s_fs), 0);
    check("arst_ready", 32'(s_ready), 1);
    @(posedge clk); #1;
    reset  = 1'b0;
    en_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      en_cnt += int'(s_en);
    end
    check("arst_no_resume", 32'(en_cnt), 0);
    run_single(99, 4'b1101, 8'h17);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
